freq_counter: RTL and testbench

// - Frequency counter for one project slot of the multi-project user area.
// - Counts rising edges of an external pin continuously (exposed to the bus) and per gate window.
// - Each completed window count is sent out as an 8N1 UART frame sequence on a pin.
// - Configured through a 32-bit write-only register strobe interface decoded by the harness.

---
 rtl/freq_counter_pkg.sv | 30 +++
 rtl/uart_tx_8n1.sv | 110 +++++++++++
 rtl/freq_counter.sv | 153 +++++++++++++++
 tb/tb_freq_counter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_counter_pkg.sv
// Shared constants, UART state encoding and helpers for freq_counter.
// Report format selected by FREQ_CNT_ASCII_EN (ASCII hex + CRLF vs raw bytes).
package freq_counter_pkg;

    localparam logic [3:0] REG_DIV    = 4'd0;
    localparam logic [3:0] REG_PERIOD = 4'd1;

`ifdef FREQ_CNT_ASCII_EN
    localparam int REPORT_LEN = 10;
`else
    localparam int REPORT_LEN = 4;
`endif

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // A zero divider or period is treated as one
    function automatic logic [31:0] at_least_one(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter; divider latched per byte, back-to-back bytes
// are taken on the last stop-bit cycle so no idle gap is inserted.
module uart_tx_8n1
    import freq_counter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data,
    input  logic        valid,
    input  logic [31:0] div,
    output logic        ready,
    output logic        busy,
    output logic        tx
);

    uart_state_t state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [31:0] div_q, div_n;
    logic [2:0]  bit_idx, bit_n;
    logic [7:0]  shreg, shreg_n;
    logic        tx_q, tx_n;
    logic        last;

    assign last = (cnt == div_q - 32'd1);
    assign busy = (state != IDLE);
    assign tx   = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            div_q   <= 32'd1;
            bit_idx <= '0;
            shreg   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            div_q   <= div_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
            tx_q    <= tx_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        div_n   = div_q;
        bit_n   = bit_idx;
        shreg_n = shreg;
        tx_n    = tx_q;
        ready   = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                tx_n  = 1'b1;
                if (valid) begin
                    state_n = START;
                    cnt_n   = '0;
                    shreg_n = data;
                    div_n   = at_least_one(div);
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (last) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    bit_n   = '0;
                    tx_n    = shreg[0];
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            DATA: begin
                if (last) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n   = bit_idx + 3'd1;
                        shreg_n = shreg >> 1;
                        tx_n    = shreg[1];
                    end
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            STOP: begin
                if (last) begin
                    ready = 1'b1;
                    cnt_n = '0;
                    if (valid) begin
                        state_n = START;
                        shreg_n = data;
                        div_n   = at_least_one(div);
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
        endcase
    end

endmodule

// File: rtl/freq_counter.sv
// Frequency counter: synchronized edge counting, gated window count and
// UART report sequencer (format chosen by FREQ_CNT_ASCII_EN).
module freq_counter
    import freq_counter_pkg::*;
#(
    parameter logic [31:0] DIV_RESET    = 32'd87,
    parameter logic [31:0] PERIOD_RESET = 32'd10_000_000,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  addr,
    input  logic [31:0] value,
    input  logic        strobe,
    input  logic        samplee,
    output logic [31:0] oc,
    output logic        tx
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_d;
    logic                   rise;

    logic [31:0] div_r;
    logic [31:0] period_r;
    logic        wr_div;
    logic        wr_per;

    logic [31:0] oc_r;
    logic [31:0] gate_cnt;
    logic [31:0] win_cnt;
    logic [31:0] win_sum;
    logic [31:0] per_eff;
    logic        win_end;
    logic [31:0] result;
    logic        result_vld;

    logic        active;
    logic [3:0]  idx;
    logic [31:0] rpt;
    logic [7:0]  tx_byte;
    logic [4:0]  sh;
    logic        ready;
    logic        busy;
    logic        accept;
    logic        last_byte;

    assign wr_div = strobe && (addr == REG_DIV);
    assign wr_per = strobe && (addr == REG_PERIOD);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync   <= '0;
            sync_d <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], samplee};
            sync_d <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~sync_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_r    <= DIV_RESET;
            period_r <= PERIOD_RESET;
        end else begin
            if (wr_div) div_r <= value;
            if (wr_per) period_r <= value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) oc_r <= '0;
        else     oc_r <= oc_r + {31'd0, rise};
    end

    assign oc = oc_r;

    assign per_eff = at_least_one(period_r);
    // >= so a period shrunk below the running count still ends the window
    assign win_end = (gate_cnt >= per_eff - 32'd1);
    assign win_sum = (&win_cnt) ? win_cnt : win_cnt + {31'd0, rise};

    always_ff @(posedge clk) begin
        if (rst) begin
            gate_cnt   <= '0;
            win_cnt    <= '0;
            result     <= '0;
            result_vld <= 1'b0;
        end else begin
            result_vld <= 1'b0;
            if (wr_per) begin
                gate_cnt <= '0;
                win_cnt  <= '0;
            end else if (win_end) begin
                gate_cnt   <= '0;
                win_cnt    <= '0;
                result     <= win_sum;
                result_vld <= 1'b1;
            end else begin
                gate_cnt <= gate_cnt + 32'd1;
                win_cnt  <= win_sum;
            end
        end
    end

    assign accept    = active & ready;
    assign last_byte = (idx == 4'(REPORT_LEN - 1));

    // Results arriving while any byte is still queued or on the wire are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            idx    <= '0;
            rpt    <= '0;
        end else if (!active) begin
            if (result_vld && !busy) begin
                active <= 1'b1;
                idx    <= '0;
                rpt    <= result;
            end
        end else if (accept) begin
            if (last_byte) active <= 1'b0;
            idx <= idx + 4'd1;
        end
    end

`ifdef FREQ_CNT_ASCII_EN
    assign sh = 5'd28 - {idx[2:0], 2'b00};

    always_comb begin
        tx_byte = 8'h0A;
        if (idx < 4'd8)       tx_byte = hex_ascii(rpt[sh +: 4]);
        else if (idx == 4'd8) tx_byte = 8'h0D;
    end
`else
    assign sh      = 5'd24 - {idx[1:0], 3'b000};
    assign tx_byte = rpt[sh +: 8];
`endif

    uart_tx_8n1 u_uart (
        .clk   (clk),
        .rst   (rst),
        .data  (tx_byte),
        .valid (active),
        .div   (div_r),
        .ready (ready),
        .busy  (busy),
        .tx    (tx)
    );

endmodule

// File: tb/tb_freq_counter.sv
// Self-checking bench for freq_counter; randomized pulses and window configs
// checked against an edge/window model and a bit-level UART receiver.
module tb_freq_counter;

`ifdef FREQ_CNT_ASCII_EN
    localparam int LEN = 10;
`else
    localparam int LEN = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  addr;
    logic [31:0] value;
    logic        strobe;
    logic        samplee;
    logic [31:0] oc;
    logic        tx;

    int n_pass  = 0;
    int n_total = 0;

    logic       pulse_lvl;
    logic       tog_lvl;
    logic       tog_on;
    int         tog_h;
    int         tog_cnt;
    int         tog_edges;
    int         tog_base;
    int         pulse_edges;
    int         tx_low_cnt;
    logic [7:0] rx_bytes [LEN];

    always #5 clk = ~clk;

    assign samplee = pulse_lvl | tog_lvl;

    freq_counter dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .value   (value),
        .strobe  (strobe),
        .samplee (samplee),
        .oc      (oc),
        .tx      (tx)
    );

    initial begin
        tog_lvl   = 1'b0;
        tog_cnt   = 0;
        tog_edges = 0;
        forever begin
            @(negedge clk);
            if (tog_on) begin
                if (tog_cnt >= tog_h - 1) begin
                    tog_cnt = 0;
                    tog_lvl = ~tog_lvl;
                    if (tog_lvl) tog_edges++;
                end else begin
                    tog_cnt++;
                end
            end else begin
                tog_lvl = 1'b0;
                tog_cnt = 0;
            end
        end
    end

    initial begin
        tx_low_cnt = 0;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) tx_low_cnt++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_oc();
        return 32'(pulse_edges + tog_edges - tog_base);
    endfunction

    function automatic logic [7:0] exp_byte(input logic [31:0] v, input int i);
`ifdef FREQ_CNT_ASCII_EN
        string s;
        s = $sformatf("%08X\r\n", v);
        return s[i];
`else
        return 8'(v >> (8 * (3 - i)));
`endif
    endfunction

    task automatic wr(input logic [3:0] a, input logic [31:0] v);
        @(negedge clk);
        addr   = a;
        value  = v;
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
    endtask

    task automatic wait_idle(input int dv);
        int t;
        int quiet;
        t     = 0;
        quiet = 0;
        while (quiet < 12 * dv && t < 20000) begin
            @(negedge clk);
            t++;
            quiet = (tx === 1'b1) ? quiet + 1 : 0;
        end
        check("idle", 32'(quiet >= 12 * dv), 1);
    endtask

    // Samples every cycle of every bit; also checks bytes follow with no gap
    task automatic recv_report(input int dv);
        int t;
        t = 0;
        while (tx !== 1'b0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("rx_start_seen", 32'(tx === 1'b0), 1);
        for (int k = 0; k < LEN; k++) begin
            logic [9:0] bits;
            logic       first;
            int         nonuni;
            nonuni = 0;
            for (int b = 0; b < 10; b++) begin
                first   = tx;
                bits[b] = first;
                for (int s = 0; s < dv; s++) begin
                    if (tx !== first) nonuni++;
                    @(negedge clk);
                end
            end
            check("start_bit", {31'd0, bits[0]}, 0);
            check("stop_bit", {31'd0, bits[9]}, 1);
            check("bit_width", nonuni, 0);
            rx_bytes[k] = bits[8:1];
        end
    endtask

    task automatic check_report(input string tag, input logic [31:0] v);
        for (int i = 0; i < LEN; i++)
            check(tag, {24'd0, rx_bytes[i]}, {24'd0, exp_byte(v, i)});
    endtask

    initial begin
        int n;
        int h;
        int m;
        int d;
        int t;
        bit ok0;
        bit ok1;

        rst         = 1'b1;
        addr        = '0;
        value       = '0;
        strobe      = 1'b0;
        pulse_lvl   = 1'b0;
        tog_on      = 1'b0;
        tog_h       = 5;
        tog_base    = 0;
        pulse_edges = 0;

        repeat (3) @(negedge clk);
        check("reset_oc", oc, 0);
        check("reset_tx", {31'd0, tx}, 1);
        rst = 1'b0;

        repeat (5) begin
            pulse_lvl = 1'b1;
            repeat (10) @(negedge clk);
            pulse_lvl = 1'b0;
            repeat (10) @(negedge clk);
        end
        pulse_edges += 5;
        check("oc_five", oc, exp_oc());

        n = $urandom_range(3, 8);
        for (int i = 0; i < n; i++) begin
            pulse_lvl = 1'b1;
            repeat ($urandom_range(1, 6)) @(negedge clk);
            pulse_lvl = 1'b0;
            repeat ($urandom_range(1, 6)) @(negedge clk);
        end
        pulse_edges += n;
        repeat (6) @(negedge clk);
        check("oc_random_pulses", oc, exp_oc());
        check("tx_idle_no_window", tx_low_cnt, 0);

        // Fixed window: 10 edges per 100-cycle window, divider 4
        tog_h  = 5;
        tog_on = 1'b1;
        repeat (30) @(negedge clk);
        wr(4'd0, 32'd4);
        wr(4'd1, 32'd100);
        wr(4'd2, 32'hFFFF_FFFF);
        wr(4'd15, 32'hFFFF_FFFF);
        recv_report(4);
        check_report("rep10_a", 32'd10);
        check("lsb_first_0a", {24'd0, rx_bytes[LEN-1]}, 32'h0A);
        recv_report(4);
        check_report("rep10_b", 32'd10);
        tog_on = 1'b0;
        repeat (6) @(negedge clk);
        check("oc_after_toggle", oc, exp_oc());

        // Random window length, edge rate and divider
        wr(4'd1, 32'h0010_0000);
        wait_idle(4);
        h     = $urandom_range(2, 6);
        m     = $urandom_range(3, 12);
        d     = $urandom_range(2, 6);
        tog_h = h;
        tog_on = 1'b1;
        repeat (4 * h + 10) @(negedge clk);
        wr(4'd0, 32'(d));
        wr(4'd1, 32'(2 * h * m));
        recv_report(d);
        check_report("rep_rand_a", 32'(m));
        recv_report(d);
        check_report("rep_rand_b", 32'(m));

        // period=1: windows end every cycle while the UART is busy
        wr(4'd1, 32'h0010_0000);
        wait_idle(d);
        tog_h = 1;
        repeat (8) @(negedge clk);
        wr(4'd0, 32'd4);
        wr(4'd1, 32'd1);
        for (int r = 0; r < 2; r++) begin
            recv_report(4);
            ok0 = 1'b1;
            ok1 = 1'b1;
            for (int i = 0; i < LEN; i++) begin
                if (rx_bytes[i] !== exp_byte(32'd0, i)) ok0 = 1'b0;
                if (rx_bytes[i] !== exp_byte(32'd1, i)) ok1 = 1'b0;
            end
            check("p1_frame_intact", {31'd0, ok0 | ok1}, 1);
        end

        // Reset in the middle of a byte
        wr(4'd1, 32'h0010_0000);
        wait_idle(4);
        tog_h = 5;
        repeat (30) @(negedge clk);
        wr(4'd1, 32'd100);
        t = 0;
        while (tx !== 1'b0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("pre_reset_frame_seen", {31'd0, tx === 1'b0}, 1);
        tog_on = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", {31'd0, tx}, 1);
        check("rst_mid_oc", oc, 0);
        rst         = 1'b0;
        tog_base    = tog_edges;
        pulse_edges = 0;

        tog_on = 1'b1;
        repeat (30) @(negedge clk);
        wr(4'd0, 32'd4);
        wr(4'd1, 32'd100);
        t = 0;
        while (tx !== 1'b0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("fresh_after_window", {31'd0, (t >= 98 && t <= 106)}, 1);
        recv_report(4);
        check_report("rep_after_rst", 32'd10);
        tog_on = 1'b0;
        repeat (6) @(negedge clk);
        check("oc_after_rst", oc, exp_oc());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
